// File: rtl/disp_scan_sched_if.sv
// Load handshake between upstream counter/BCD logic and the display scan
// scheduler.
//   load_valid  : new display data offered (master -> slave)
//   load_digits : four BCD digits, [3:0] = digit0 (units) .. [15:12] = digit3
//   load_dp     : decimal point per digit, bit i = digit i
//   load_ready  : scheduler's pending buffer is empty (slave -> master)
// A transfer happens on a cycle with load_valid & load_ready; the master holds
// its data while load_valid=1 and load_ready=0.
interface disp_scan_sched_if;
    logic        load_valid;
    logic [15:0] load_digits;
    logic [3:0]  load_dp;
    logic        load_ready;

    modport master (
        output load_valid,
        output load_digits,
        output load_dp,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_digits,
        input  load_dp,
        output load_ready
    );
endinterface

// File: rtl/disp_scan_sched.sv
// Time-multiplexed scan scheduler for a 4-digit common-anode 7-segment display.
// Drives the active-low digit selects and shares one segment bus between the
// four digits, with per-slot dead time, PWM brightness, leading-zero blanking
// and a double-buffered load path that only updates the shown digits at a
// frame boundary.
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   enable      : scan enable (0 = dark, counters parked at slot 0)
//   brightness  : PWM level 0..15, sampled at the start of each slot
//   blank_lz    : leading-zero suppression enable
//   load        : load handshake (slave side)
//   nib, dp     : BCD nibble / decimal point of the current slot, to encoder
//   seg_blank   : 1 = top level forces segments off
//   sel_seg     : active-low digit select
//   frame_tick  : 1-cycle pulse on the last cycle of slot 3
// All outputs are registered and lag the internal slot/slot_cnt by one cycle.
module disp_scan_sched #(
    parameter int DEAD_CYC = 212,
    parameter int STEP_CYC = 768
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [3:0]         brightness,
    input  logic               blank_lz,
    disp_scan_sched_if.slave   load,
    output logic [3:0]         nib,
    output logic               dp,
    output logic               seg_blank,
    output logic [3:0]         sel_seg,
    output logic               frame_tick
);

    localparam int SLOT_CYC = DEAD_CYC + 16 * STEP_CYC;
    localparam int CW       = $clog2(SLOT_CYC);

    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYC - 1);
    localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYC);
    localparam logic [CW-1:0] CNT_STEP = CW'(STEP_CYC);

    typedef enum logic [1:0] {
        SLOT0 = 2'd0,
        SLOT1 = 2'd1,
        SLOT2 = 2'd2,
        SLOT3 = 2'd3
    } slot_t;

    slot_t         slot;
    logic [CW-1:0] slot_cnt;

    logic [15:0]   act_digits;
    logic [3:0]    act_dp;
    logic [15:0]   pend_digits;
    logic [3:0]    pend_dp;
    logic          pend_full;

    logic [3:0]    b_reg;     // brightness held for the current slot
    logic          blk_reg;   // current slot's digit is leading-zero blanked

    logic          accept;
    logic          xfer;
    logic [15:0]   src_digits;
    logic [3:0]    src_dp;
    logic [3:0]    lz;
    logic [3:0]    cur_nib;
    logic          cur_dp;
    logic          cur_blk;
    logic [3:0]    pattern;
    logic [CW-1:0] win_end;
    logic          lit;

    assign load.load_ready = !pend_full;

    always_comb begin
        accept = load.load_valid && !pend_full;
        // The frame boundary is the cycle frame_tick is high; while disabled
        // every cycle acts as a boundary so pending drains immediately.
        xfer   = pend_full && (!enable || frame_tick);

        // The digit for slot 0 is latched in the same cycle as the transfer,
        // so forward pending to avoid showing a stale digit0 for a whole slot.
        src_digits = xfer ? pend_digits : act_digits;
        src_dp     = xfer ? pend_dp     : act_dp;

        lz[3] = blank_lz && (src_digits[15:12] == 4'd0) && !src_dp[3];
        lz[2] = lz[3]    && (src_digits[11:8]  == 4'd0) && !src_dp[2];
        lz[1] = lz[2]    && (src_digits[7:4]   == 4'd0) && !src_dp[1];
        lz[0] = 1'b0;

        cur_nib = src_digits[3:0];
        cur_dp  = src_dp[0];
        cur_blk = lz[0];
        pattern = 4'b1110;
        case (slot)
            SLOT0: begin
                cur_nib = src_digits[3:0];
                cur_dp  = src_dp[0];
                cur_blk = lz[0];
                pattern = 4'b1110;
            end
            SLOT1: begin
                cur_nib = src_digits[7:4];
                cur_dp  = src_dp[1];
                cur_blk = lz[1];
                pattern = 4'b1101;
            end
            SLOT2: begin
                cur_nib = src_digits[11:8];
                cur_dp  = src_dp[2];
                cur_blk = lz[2];
                pattern = 4'b1011;
            end
            SLOT3: begin
                cur_nib = src_digits[15:12];
                cur_dp  = src_dp[3];
                cur_blk = lz[3];
                pattern = 4'b0111;
            end
            default: ;
        endcase

        // b_reg/blk_reg are refreshed at slot_cnt=0, which always falls in
        // the dead time, so they are valid wherever the window can be open.
        win_end = CNT_DEAD + CW'(b_reg) * CNT_STEP;
        lit     = (slot_cnt >= CNT_DEAD) && (slot_cnt < win_end) && !blk_reg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot        <= SLOT0;
            slot_cnt    <= '0;
            act_digits  <= '0;
            act_dp      <= '0;
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_full   <= 1'b0;
            b_reg       <= '0;
            blk_reg     <= 1'b0;
            nib         <= '0;
            dp          <= 1'b0;
            seg_blank   <= 1'b1;
            sel_seg     <= '1;
            frame_tick  <= 1'b0;
        end else begin
            if (accept) begin
                pend_digits <= load.load_digits;
                pend_dp     <= load.load_dp;
                pend_full   <= 1'b1;
            end else if (xfer) begin
                pend_full   <= 1'b0;
            end

            if (xfer) begin
                act_digits <= pend_digits;
                act_dp     <= pend_dp;
            end

            if (!enable) begin
                slot       <= SLOT0;
                slot_cnt   <= '0;
                sel_seg    <= '1;
                seg_blank  <= 1'b1;
                frame_tick <= 1'b0;
            end else begin
                if (slot_cnt == CNT_LAST) begin
                    slot_cnt <= '0;
                    slot     <= slot_t'(2'(slot + 2'd1));
                end else begin
                    slot_cnt <= slot_cnt + CW'(1);
                end

                if (slot_cnt == '0) begin
                    nib     <= cur_nib;
                    dp      <= cur_dp;
                    blk_reg <= cur_blk;
                    b_reg   <= brightness;
                end

                sel_seg    <= lit ? pattern : '1;
                seg_blank  <= !lit;
                frame_tick <= (slot == SLOT3) && (slot_cnt == CNT_LAST);
            end
        end
    end

endmodule

// File: tb/tb_disp_scan_sched.sv
// Directed bench for disp_scan_sched with DEAD_CYC=2, STEP_CYC=4 (66-cycle
// slots, 264-cycle frames). Inputs are driven and outputs sampled on the
// falling clock edge.
module tb_disp_scan_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] brightness = 4'd0;
    logic       blank_lz = 1'b0;
    logic [3:0] nib;
    logic       dp;
    logic       seg_blank;
    logic [3:0] sel_seg;
    logic       frame_tick;

    disp_scan_sched_if lif ();

    disp_scan_sched #(
        .DEAD_CYC (2),
        .STEP_CYC (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .brightness (brightness),
        .blank_lz   (blank_lz),
        .load       (lif),
        .nib        (nib),
        .dp         (dp),
        .seg_blank  (seg_blank),
        .sel_seg    (sel_seg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  p;
        logic        lz;
        logic [3:0]  br;
        logic [15:0] enib;   // expected nib per slot, [3:0] = slot 0
        logic [3:0]  edp;    // expected dp per slot
        logic [31:0] eon;    // expected lit cycles per slot, byte i = slot i
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_tick(input string name);
        int k = 0;
        do begin
            step();
            k++;
        end while (!frame_tick && k < 400);
        check({name, " tick seen"}, int'(frame_tick), 1);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        int k = 0;
        while (!lif.load_ready && k < 400) begin
            step();
            k++;
        end
        check("ready before load", int'(lif.load_ready), 1);
        lif.load_valid  = 1'b1;
        lif.load_digits = d;
        lif.load_dp     = p;
        step();
        lif.load_valid  = 1'b0;
    endtask

    // Call on the negedge where frame_tick is high; observes the next frame
    // and ends on that frame's frame_tick cycle.
    task automatic check_frame(input string name, input logic [15:0] enib,
                               input logic [3:0] edp, input logic [31:0] eon);
        int on_c [4];
        int nb [4];
        int dpv [4];
        int first [4];
        int bad;
        logic [3:0] pat;
        logic [3:0] one;
        bad = 0;
        one = 4'b0001;
        for (int s = 0; s < 4; s++) begin
            on_c[s]  = 0;
            first[s] = -1;
            nb[s]    = -1;
            dpv[s]   = -1;
            pat = 4'b1111 ^ (one << s);
            for (int c = 0; c < 66; c++) begin
                step();
                if (sel_seg != 4'hF) begin
                    on_c[s]++;
                    if (first[s] < 0) first[s] = c;
                    if (sel_seg != pat) bad++;
                end
                if (seg_blank != (sel_seg == 4'hF)) bad++;
                if (frame_tick != (s == 3 && c == 65)) bad++;
                if (c == 33) begin
                    nb[s]  = int'(nib);
                    dpv[s] = int'(dp);
                end
            end
        end
        for (int s = 0; s < 4; s++) begin
            check($sformatf("%s nib slot%0d", name, s), nb[s], int'(enib[s*4 +: 4]));
            check($sformatf("%s dp slot%0d", name, s), dpv[s], int'(edp[s]));
            check($sformatf("%s lit slot%0d", name, s), on_c[s], int'(eon[s*8 +: 8]));
            if (eon[s*8 +: 8] != 8'd0)
                check($sformatf("%s first lit slot%0d", name, s), first[s], 2);
        end
        check({name, " sel/blank/tick shape"}, bad, 0);
    endtask

    vec_t vecs [8];

    initial begin
        int k;
        int rh;
        int cnt;
        logic prev_ft;
        logic seen;

        vecs[0] = '{d:16'h0000, p:4'h0, lz:1'b0, br:4'd15, enib:16'h0000, edp:4'h0, eon:{8'd60, 8'd60, 8'd60, 8'd60}};
        vecs[1] = '{d:16'h1234, p:4'h0, lz:1'b0, br:4'd15, enib:16'h1234, edp:4'h0, eon:{8'd60, 8'd60, 8'd60, 8'd60}};
        vecs[2] = '{d:16'h0050, p:4'h0, lz:1'b1, br:4'd15, enib:16'h0050, edp:4'h0, eon:{8'd0, 8'd0, 8'd60, 8'd60}};
        vecs[3] = '{d:16'h0050, p:4'h4, lz:1'b1, br:4'd15, enib:16'h0050, edp:4'h4, eon:{8'd0, 8'd60, 8'd60, 8'd60}};
        vecs[4] = '{d:16'h0000, p:4'h0, lz:1'b1, br:4'd8,  enib:16'h0000, edp:4'h0, eon:{8'd0, 8'd0, 8'd0, 8'd32}};
        vecs[5] = '{d:16'h1234, p:4'h0, lz:1'b0, br:4'd0,  enib:16'h1234, edp:4'h0, eon:{8'd0, 8'd0, 8'd0, 8'd0}};
        vecs[6] = '{d:16'h9087, p:4'h1, lz:1'b1, br:4'd1,  enib:16'h9087, edp:4'h1, eon:{8'd4, 8'd4, 8'd4, 8'd4}};
        vecs[7] = '{d:16'h0305, p:4'h0, lz:1'b1, br:4'd3,  enib:16'h0305, edp:4'h0, eon:{8'd0, 8'd12, 8'd12, 8'd12}};

        lif.load_valid  = 1'b0;
        lif.load_digits = '0;
        lif.load_dp     = '0;

        // Reset values
        #2 rst = 1'b0;
        step();
        step();
        check("rst sel_seg", int'(sel_seg), 15);
        check("rst seg_blank", int'(seg_blank), 1);
        check("rst nib", int'(nib), 0);
        check("rst dp", int'(dp), 0);
        check("rst frame_tick", int'(frame_tick), 0);
        check("rst load_ready", int'(lif.load_ready), 1);
        rst = 1'b1;
        step();

        // First frame timing at full brightness
        enable = 1'b1;
        brightness = 4'd15;
        for (int i = 0; i < 132; i++) begin
            step();
            if (i == 1)  check("t1 dead cnt1", int'(sel_seg), 15);
            if (i == 2)  check("t1 slot0 first lit", int'(sel_seg), 14);
            if (i == 61) check("t1 slot0 last lit", int'(sel_seg), 14);
            if (i == 62) check("t1 slot0 tail dark", int'(sel_seg), 15);
            if (i == 68) check("t1 slot1 lit", int'(sel_seg), 13);
        end
        wait_tick("t1 first");
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!frame_tick && cnt < 400);
        check("t1 frame period", cnt, 264);

        // Table: load, wait one boundary, check the following frame
        for (int v = 0; v < 8; v++) begin
            brightness = vecs[v].br;
            blank_lz   = vecs[v].lz;
            do_load(vecs[v].d, vecs[v].p);
            wait_tick($sformatf("vec%0d", v));
            check_frame($sformatf("vec%0d", v), vecs[v].enib, vecs[v].edp, vecs[v].eon);
        end

        // Mid-frame accept: current frame keeps old data, ready low until
        // the cycle after frame_tick
        brightness = 4'd15;
        blank_lz   = 1'b0;
        do_load(16'h1234, 4'h0);
        wait_tick("t2 a");
        wait_tick("t2 b");
        for (int i = 0; i < 100; i++) step();
        do_load(16'h5678, 4'h0);
        check("t2 ready after accept", int'(lif.load_ready), 0);
        rh = 0;
        k = 0;
        while (!frame_tick && k < 400) begin
            step();
            k++;
            if (lif.load_ready) rh++;
        end
        check("t2 tick seen", int'(frame_tick), 1);
        check("t2 ready high mid-frame", rh, 0);
        check("t2 ready at tick", int'(lif.load_ready), 0);
        check("t2 old digit3 at tick", int'(nib), 1);
        step();
        check("t2 ready after tick", int'(lif.load_ready), 1);
        check("t2 new digit0", int'(nib), 8);

        // Back-to-back A then B with valid held
        lif.load_valid  = 1'b1;
        lif.load_digits = 16'h2468;
        lif.load_dp     = 4'h0;
        step();
        check("t5 ready after A", int'(lif.load_ready), 0);
        lif.load_digits = 16'h1357;
        prev_ft = 1'b0;
        seen    = 1'b0;
        k = 0;
        while (!lif.load_ready && k < 400) begin
            prev_ft = frame_tick;
            step();
            k++;
            if (frame_tick) seen = 1'b1;
        end
        check("t5 ready rose", int'(lif.load_ready), 1);
        check("t5 tick before ready", int'(seen), 1);
        check("t5 ready right after tick", int'(prev_ft), 1);
        check("t5 A digit0 shown", int'(nib), 8);
        step();
        lif.load_valid = 1'b0;
        check("t5 B accepted", int'(lif.load_ready), 0);
        wait_tick("t5");
        check_frame("t5 B", 16'h1357, 4'h0, {8'd60, 8'd60, 8'd60, 8'd60});

        // Accept in the boundary cycle itself (pending empty)
        lif.load_valid  = 1'b1;
        lif.load_digits = 16'h9999;
        lif.load_dp     = 4'hF;
        step();
        lif.load_valid = 1'b0;
        check("sim ready after accept", int'(lif.load_ready), 0);
        for (int i = 0; i < 30; i++) step();
        check("sim old digit0 kept", int'(nib), 7);
        wait_tick("sim");
        check_frame("sim C", 16'h9999, 4'hF, {8'd60, 8'd60, 8'd60, 8'd60});

        // Brightness change mid-slot applies from the next slot
        for (int i = 0; i < 10; i++) step();
        brightness = 4'd1;
        cnt = 0;
        for (int i = 10; i < 66; i++) begin
            step();
            if (sel_seg != 4'hF) cnt++;
        end
        check("t4 rest of slot0 lit", cnt, 52);
        cnt = 0;
        for (int i = 0; i < 66; i++) begin
            step();
            if (sel_seg != 4'hF) cnt++;
        end
        check("t4 slot1 lit", cnt, 4);
        brightness = 4'd15;

        // Enable dropped during slot 2
        for (int i = 0; i < 20; i++) step();
        check("t6 slot2 lit before drop", int'(sel_seg), 11);
        enable = 1'b0;
        step();
        check("t6 sel off after drop", int'(sel_seg), 15);
        check("t6 blank after drop", int'(seg_blank), 1);
        do_load(16'h0426, 4'h0);
        check("t6 ready cycle after accept", int'(lif.load_ready), 0);
        step();
        check("t6 ready back while disabled", int'(lif.load_ready), 1);
        rh = 0;
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (frame_tick) rh++;
            if (sel_seg != 4'hF) cnt++;
        end
        check("t6 ticks while disabled", rh, 0);
        check("t6 lit while disabled", cnt, 0);
        enable = 1'b1;
        step();
        check("t6 restart dead0", int'(sel_seg), 15);
        check("t6 restart digit0", int'(nib), 6);
        step();
        check("t6 restart dead1", int'(sel_seg), 15);
        step();
        check("t6 restart slot0 lit", int'(sel_seg), 14);

        // Async reset mid slot 1 drops pending data
        wait_tick("t6 r");
        for (int i = 0; i < 80; i++) step();
        do_load(16'h7777, 4'h0);
        check("rst2 pending held", int'(lif.load_ready), 0);
        check("rst2 slot1 digit", int'(nib), 2);
        #2 rst = 1'b0;
        #1;
        check("rst2 sel_seg", int'(sel_seg), 15);
        check("rst2 seg_blank", int'(seg_blank), 1);
        check("rst2 nib", int'(nib), 0);
        check("rst2 load_ready", int'(lif.load_ready), 1);
        check("rst2 frame_tick", int'(frame_tick), 0);
        step();
        rst = 1'b1;
        wait_tick("rst2");
        check_frame("rst2 cleared", 16'h0000, 4'h0, {8'd60, 8'd60, 8'd60, 8'd60});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
